// File: rtl/fifo_if_pkg.sv
// Shared types and limits for the FIFO read-side master.
// Holds the default word width, FSM state encoding and read-latency bounds.
package fifo_if_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    STALL,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_buf.sv
// In-order holding buffer for words captured from the FIFO.
// Wrap-around pointers mod DEPTH; head is zero when empty.
module fifo_reader_buf
  import fifo_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     occ,
  output logic [DATA_W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage, pointers and occupancy; push into a full buffer is safe
  // only together with a pop, which the credit scheme guarantees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        if (wr_ptr == PW'(DEPTH - 1)) begin
          wr_ptr <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (pop) begin
        if (rd_ptr == PW'(DEPTH - 1)) begin
          rd_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  // Oldest word, forced to zero while nothing is buffered.
  always_comb begin
    head = '0;
    if (occ != '0) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side master: strobes the FIFO under a credit limit, captures data
// RD_LAT cycles later and replays it on a valid/ready stream.
// Optional stats counters enabled by FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_if_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]       word_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("fifo_reader: RD_LAT out of range");
  end

  logic [RD_LAT-1:0] vld;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     credits;
  logic              pop;
  logic              issue;
  logic              capture;
  logic              can_read;
  rd_state_e         state;

  fifo_reader_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .CW     (CW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head      (out_data)
  );

  // Count reads whose data has not yet been captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vld[i]);
    end
  end

  // Credit check: a slot freed by this cycle's pop may be re-issued now.
  always_comb begin
    out_valid    = (occ != '0);
    pop          = out_valid && out_ready;
    credits      = occ + inflight - CW'(pop);
    can_read     = enable && !fifo_empty;
    issue        = !reset && can_read && (credits < CW'(BUF_DEPTH));
    capture      = vld[RD_LAT-1];
    fifo_read_en = issue;
  end

  // Read-latency pipe: one bit per outstanding strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Control FSM; busy mirrors any non-idle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ, STALL: begin
          if (issue) begin
            state <= READ;
          end else if (can_read) begin
            state <= STALL;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (issue) begin
            state <= READ;
          end else if (occ + inflight == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Delivered-word counter wraps; backpressure counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
